// File: rtl/lsu_pkg.sv
// lsu_pkg: shared operation codes, FSM state codes and lane constants for the LSU.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package lsu_pkg;

  // Load/store operation encodings as seen on ls_op
  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_STORE  = 3'd2;
  localparam logic [2:0] ST_RMW_RD = 3'd3;
  localparam logic [2:0] ST_RMW_WR = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  // Lane widths in bits
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  // Halfword ops need an even address, word ops a word-aligned one; bytes never fault
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = off[0];
      OP_LW, OP_SW:         bad = (off != 2'b00);
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response handshake plus data-memory port of the load/store unit.
// Latency: n/a (wires only).
// Backpressure: req_valid held by the requester until req_ready is seen high.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  ls_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  // Requester and memory side
  modport master (
    output req_valid, ls_op, addr, wdata, mem_dout,
    input  req_ready, done, err, rdata, mem_addr, mem_din, mem_read, mem_write
  );

  // Load/store unit side
  modport slave (
    input  req_valid, ls_op, addr, wdata, mem_dout,
    output req_ready, done, err, rdata, mem_addr, mem_din, mem_read, mem_write
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: big-endian lane extraction/extension for loads and lane merge for stores.
// Latency: purely combinational.
// Backpressure: none.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  op,
  input  logic [31:0] wdata,
  output logic [31:0] ld_val,
  output logic [31:0] st_word
);

  logic [BYTE_W-1:0] lane_b;
  logic [HALF_W-1:0] lane_h;

  // Pick the addressed byte and halfword; offset 0 is the most significant lane
  always_comb begin
    lane_b = word[31:24];
    case (off)
      2'd0: lane_b = word[31:24];
      2'd1: lane_b = word[23:16];
      2'd2: lane_b = word[15:8];
      default: lane_b = word[7:0];
    endcase
    lane_h = off[1] ? word[15:0] : word[31:16];
  end

  // Extend the selected lane according to the load flavour
  always_comb begin
    ld_val = word;
    case (op)
      OP_LB:   ld_val = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ld_val = {24'd0, lane_b};
      OP_LH:   ld_val = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ld_val = {16'd0, lane_h};
      default: ld_val = word;
    endcase
  end

  // Replace the target lane of the old word with the low store data
  always_comb begin
    st_word = word;
    case (op)
      OP_SB: begin
        case (off)
          2'd0: st_word[31:24] = wdata[7:0];
          2'd1: st_word[23:16] = wdata[7:0];
          2'd2: st_word[15:8]  = wdata[7:0];
          default: st_word[7:0] = wdata[7:0];
        endcase
      end
      OP_SH: begin
        if (off[1]) st_word[15:0]  = wdata[15:0];
        else        st_word[31:16] = wdata[15:0];
      end
      OP_SW:   st_word = wdata;
      default: st_word = word;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: single-outstanding load/store unit with sub-word stores done as read-modify-write.
// Latency: done 2 cycles after accept for LOAD/SW/misaligned, 3 cycles for SB/SH.
// Backpressure: req_ready only in IDLE; requests while busy are simply not accepted.
module lsu_rmw
  import lsu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  logic [2:0]  state;
  logic [2:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] ld_val;
  logic [31:0] st_word;
  logic        accept;
  logic        unused_addr_hi;

  // Only the 4 KB window is decoded
  assign unused_addr_hi = ^bus.addr[31:12];

  assign accept = bus.req_valid && (state == ST_IDLE);

  lsu_align u_align (
    .word    (bus.mem_dout),
    .off     (addr_q[1:0]),
    .op      (op_q),
    .wdata   (wdata_q),
    .ld_val  (ld_val),
    .st_word (st_word)
  );

  // FSM, request latches and load/merge capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= 3'd0;
      addr_q  <= 12'd0;
      wdata_q <= 32'd0;
      merge_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= bus.ls_op;
            addr_q  <= bus.addr[11:0];
            wdata_q <= bus.wdata;
            if (is_misaligned(bus.ls_op, bus.addr[1:0]))       state <= ST_ERR;
            else if (bus.ls_op == OP_SW)                        state <= ST_STORE;
            else if (bus.ls_op == OP_SB || bus.ls_op == OP_SH)  state <= ST_RMW_RD;
            else                                                state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          rdata_q <= ld_val;
          state   <= ST_IDLE;
        end
        ST_RMW_RD: begin
          merge_q <= st_word;
          state   <= ST_RMW_WR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Completion pulse lands in the first IDLE cycle after a terminal state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (state == ST_LOAD) || (state == ST_STORE) ||
                (state == ST_RMW_WR) || (state == ST_ERR);
      err_q  <= (state == ST_ERR);
    end
  end

  // Write data follows the state so it is zero whenever no write is in flight
  always_comb begin
    bus.mem_din = 32'd0;
    if (state == ST_STORE)       bus.mem_din = wdata_q;
    else if (state == ST_RMW_WR) bus.mem_din = merge_q;
  end

  // Memory strobes decode straight from state so reset kills them immediately
  assign bus.mem_read  = (state == ST_LOAD)  || (state == ST_RMW_RD);
  assign bus.mem_write = (state == ST_STORE) || (state == ST_RMW_WR);
  assign bus.mem_addr  = addr_q[11:2];
  assign bus.req_ready = (state == ST_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_rmw.sv
module tb_lsu_rmw;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if bus();
  lsu_rmw dut (.clk(clk), .rst(rst), .bus(bus));

  // Data memory: combinational read, write on posedge
  logic [31:0] mem_arr [1024];
  assign bus.mem_dout = mem_arr[bus.mem_addr];
  always @(posedge clk) if (bus.mem_write) mem_arr[bus.mem_addr] <= bus.mem_din;

  // Reference state
  logic [31:0] ref_mem [1024];
  logic [31:0] ref_rdata;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  function automatic logic misal(input logic [2:0] op, input logic [31:0] a);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return (a % 2) != 0;
    if (op == OP_LW || op == OP_SW) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    int off;
    off = a % 4;
    b = (w >> (8 * (3 - off))) & 32'hFF;
    h = (w >> (16 * (1 - off / 2))) & 32'hFFFF;
    case (op)
      OP_LB:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      OP_LBU: return b;
      OP_LH:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      OP_LHU: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] w, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    int off;
    off = a % 4;
    if (op == OP_SW) return wd;
    if (op == OP_SB) begin
      sh = 8 * (3 - off);
      mask = 32'hFF << sh;
      return (w & ~mask) | ((wd & 32'hFF) << sh);
    end
    sh = 16 * (1 - off / 2);
    mask = 32'hFFFF << sh;
    return (w & ~mask) | ((wd & 32'hFFFF) << sh);
  endfunction

  // Apply the model's view of one request
  task automatic ref_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int wi;
    wi = (a / 4) % 1024;
    if (misal(op, a)) return;
    if (op <= OP_LW) ref_rdata = ref_load(op, a, ref_mem[wi]);
    else ref_mem[wi] = ref_store(op, a, ref_mem[wi], wd);
  endtask

  // Issue one request starting at a negedge; returns at the negedge where done is seen
  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output int nrd, output int nwr, output int nboth,
                        output logic e);
    int n;
    bus.ls_op = op; bus.addr = a; bus.wdata = wd; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      bad++; total++;
      $display("FAIL accept_timeout: req_ready=%b want=1", bus.req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.ls_op = 3'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
    lat = 1; nrd = 0; nwr = 0; nboth = 0;
    while (!bus.done && lat < 10) begin
      nrd += int'(bus.mem_read);
      nwr += int'(bus.mem_write);
      nboth += int'(bus.mem_read && bus.mem_write);
      @(negedge clk);
      lat++;
    end
    e = bus.err;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] exp_word;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int lat, nrd, nwr, nboth;
    logic e;
    logic [31:0] r, a, wd;
    logic [2:0] op;
    logic [31:0] old4;

    for (int i = 0; i < 1024; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
    mem_arr[5] = 32'h80FF_7F01; ref_mem[5] = 32'h80FF_7F01;
    ref_rdata = 32'd0;

    bus.req_valid = 1'b0; bus.ls_op = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_din", bus.mem_din, 32'd0);
    chk("rst_mem_rw", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    tbl[0]  = '{OP_LB,  32'h10, 32'h0,         32'h0000_0011, 1'b0, 2, 1, 0, 32'h1122_3344};
    tbl[1]  = '{OP_LB,  32'h13, 32'h0,         32'h0000_0044, 1'b0, 2, 1, 0, 32'h1122_3344};
    tbl[2]  = '{OP_LH,  32'h12, 32'h0,         32'h0000_3344, 1'b0, 2, 1, 0, 32'h1122_3344};
    tbl[3]  = '{OP_LW,  32'h10, 32'h0,         32'h1122_3344, 1'b0, 2, 1, 0, 32'h1122_3344};
    tbl[4]  = '{OP_LB,  32'h14, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 1, 0, 32'h80FF_7F01};
    tbl[5]  = '{OP_LBU, 32'h14, 32'h0,         32'h0000_0080, 1'b0, 2, 1, 0, 32'h80FF_7F01};
    tbl[6]  = '{OP_LH,  32'h16, 32'h0,         32'h0000_7F01, 1'b0, 2, 1, 0, 32'h80FF_7F01};
    tbl[7]  = '{OP_LHU, 32'h14, 32'h0,         32'h0000_80FF, 1'b0, 2, 1, 0, 32'h80FF_7F01};
    tbl[8]  = '{OP_LH,  32'h14, 32'h0,         32'hFFFF_80FF, 1'b0, 2, 1, 0, 32'h80FF_7F01};
    tbl[9]  = '{OP_SB,  32'h11, 32'hAAAA_AA55, 32'hFFFF_80FF, 1'b0, 3, 1, 1, 32'h1155_3344};
    tbl[10] = '{OP_SH,  32'h12, 32'h0000_BEEF, 32'hFFFF_80FF, 1'b0, 3, 1, 1, 32'h1155_BEEF};
    tbl[11] = '{OP_LW,  32'h12, 32'h0,         32'hFFFF_80FF, 1'b1, 2, 0, 0, 32'h1155_BEEF};
    tbl[12] = '{OP_SH,  32'h13, 32'h1234_5678, 32'hFFFF_80FF, 1'b1, 2, 0, 0, 32'h1155_BEEF};
    tbl[13] = '{OP_LH,  32'h11, 32'h0,         32'hFFFF_80FF, 1'b1, 2, 0, 0, 32'h1155_BEEF};
    tbl[14] = '{OP_LW,  32'h10, 32'h0,         32'h1155_BEEF, 1'b0, 2, 1, 0, 32'h1155_BEEF};

    for (int i = 0; i < 15; i++) begin
      do_req(tbl[i].op, tbl[i].a, tbl[i].wd, lat, nrd, nwr, nboth, e);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_nrd", i), nrd, tbl[i].nrd);
      chk($sformatf("vec%0d_nwr", i), nwr, tbl[i].nwr);
      chk($sformatf("vec%0d_rdata", i), bus.rdata, tbl[i].exp_rd);
      chk($sformatf("vec%0d_word", i), mem_arr[tbl[i].a[11:2]], tbl[i].exp_word);
      ref_apply(tbl[i].op, tbl[i].a, tbl[i].wd);
    end

    // Back-to-back with req_valid held: LW, SW in its done cycle, LW in that done cycle
    bus.ls_op = OP_LW; bus.addr = 32'h10; bus.wdata = 32'd0; bus.req_valid = 1'b1;
    chk("b2b_ready0", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    chk("b2b_busy", 32'(bus.req_ready), 32'd0);
    chk("b2b_nodone", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("b2b_done1", {30'd0, bus.done, bus.req_ready}, 32'd3);
    chk("b2b_rd1", bus.rdata, 32'h1155_BEEF);
    bus.ls_op = OP_SW; bus.addr = 32'h20; bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("b2b_sw_wr", 32'(bus.mem_write), 32'd1);
    chk("b2b_sw_din", bus.mem_din, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("b2b_done2", {30'd0, bus.done, bus.req_ready}, 32'd3);
    bus.ls_op = OP_LW; bus.addr = 32'h20;
    @(negedge clk);
    chk("b2b_lw_rd", 32'(bus.mem_read), 32'd1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_done3", 32'(bus.done), 32'd1);
    chk("b2b_rd3", bus.rdata, 32'hDEAD_BEEF);
    ref_mem[8] = 32'hDEAD_BEEF;
    ref_rdata = 32'hDEAD_BEEF;

    // Randomised traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      r = $urandom;
      a = (r & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      op = 3'($urandom_range(0, 7));
      wd = $urandom;
      do_req(op, a, wd, lat, nrd, nwr, nboth, e);
      ref_apply(op, a, wd);
      chk($sformatf("rnd%0d_err", i), 32'(e), 32'(misal(op, a)));
      chk($sformatf("rnd%0d_lat", i), lat,
          (!misal(op, a) && (op == OP_SB || op == OP_SH)) ? 3 : 2);
      chk($sformatf("rnd%0d_rdata", i), bus.rdata, ref_rdata);
      chk($sformatf("rnd%0d_word", i), mem_arr[a[11:2]], ref_mem[a[11:2]]);
      chk($sformatf("rnd%0d_overlap", i), nboth, 0);
    end

    // Reset during RMW_WR of SB 0x10
    old4 = ref_mem[4];
    bus.ls_op = OP_SB; bus.addr = 32'h10; bus.wdata = 32'h0000_0077; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstw_rmw_rd", 32'(bus.mem_read), 32'd1);
    @(posedge clk);
    #2;
    chk("rstw_rmw_wr", 32'(bus.mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_wr_drop", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    chk("rstw_ready", 32'(bus.req_ready), 32'd1);
    chk("rstw_done_err", {30'd0, bus.done, bus.err}, 32'd0);
    chk("rstw_rdata", bus.rdata, 32'd0);
    chk("rstw_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rstw_mem_din", bus.mem_din, 32'd0);
    @(posedge clk);
    #1;
    chk("rstw_word_kept", mem_arr[4], old4);
    @(negedge clk);
    rst = 1'b0;
    ref_rdata = 32'd0;
    @(negedge clk);
    do_req(OP_LW, 32'h10, 32'd0, lat, nrd, nwr, nboth, e);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_err", 32'(e), 32'd0);
    chk("post_rst_rdata", bus.rdata, old4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
